pipe_ctrl: RTL and testbench

Pipeline hazard and control-flow sequencer for the 5-stage RISC-V core. It sits beside decode and execute and drives the stall and flush inputs of the IF, ID and EX stage registers. It detects load-use hazards, turns taken branches, jumps and traps from the execute output register into front-end redirects, and serialises CSR instructions. It owns a small FSM (RUN, CSR_WAIT, TRAP_ENTER) that sequences trap entry and CSR drain.

---
 rtl/pipe_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / control-flow sequencer: load-use stall, redirect on branch/jump/trap, CSR drain.
// Latency: stalls, flushes and branch/jump redirects are combinational; trap commit fires one cycle after detection.
// Backpressure: mem_busy stalls IF/ID/EX, suppresses all flushes/redirects and freezes the FSM.
// Optional: define PIPE_CTRL_CSR_SERIAL_EN to build the CSR_WAIT drain state.
module pipe_ctrl #(
    parameter int XLEN      = 64,
    parameter int CSR_DRAIN = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            id_is_csr,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic            ex_jump_taken,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic [XLEN-1:0] ex_jump_target,
    input  logic            ex_trap,
    input  logic [3:0]      ex_trap_cause,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mem_busy,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            flush_if,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_take,
    output logic [3:0]      trap_cause_out,
    output logic [XLEN-1:0] trap_epc,
    output logic            busy
);

`ifdef PIPE_CTRL_CSR_SERIAL_EN
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        CSR_WAIT   = 2'd1,
        TRAP_ENTER = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_ENTER = 2'd2
    } state_t;
`endif

    state_t            state, state_d;
    logic [3:0]        cause_q, cause_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic              lu;
    logic              legal;

`ifdef PIPE_CTRL_CSR_SERIAL_EN
    logic [1:0]        csr_cnt, csr_cnt_d;
`else
    // CSR serialisation not built: the CSR flag and drain depth are intentionally unused.
    logic              unused_csr;
    assign unused_csr = &{1'b0, id_is_csr, 1'(CSR_DRAIN)};
`endif

    // Load-use hazard: a load in ID/EX writes a register the IF/ID instruction reads.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    // State, drain counter and latched trap info.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= RUN;
            cause_q <= 4'd0;
            epc_q   <= '0;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
            csr_cnt <= 2'd0;
`endif
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
            csr_cnt <= csr_cnt_d;
`endif
        end
    end

    // Priority-ordered next-state and stall/flush/redirect decode.
    always_comb begin
        state_d        = state;
        cause_d        = cause_q;
        epc_d          = epc_q;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
        csr_cnt_d      = csr_cnt;
`endif
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        flush_if       = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_take      = 1'b0;
        trap_cause_out = 4'd0;
        trap_epc       = '0;

`ifdef PIPE_CTRL_CSR_SERIAL_EN
        legal = (state == RUN) || (state == CSR_WAIT) || (state == TRAP_ENTER);
`else
        legal = (state == RUN) || (state == TRAP_ENTER);
`endif
        busy = legal && (state != RUN);

        if (!legal) begin
            // Corrupted encoding: quietly fall back to RUN.
            state_d = RUN;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
            csr_cnt_d = 2'd0;
`endif
        end else if (mem_busy) begin
            // Whole pipe frozen; any pending trap waits for memory.
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (state == TRAP_ENTER) begin
            trap_take      = 1'b1;
            trap_cause_out = cause_q;
            trap_epc       = epc_q;
            redirect_valid = 1'b1;
            redirect_pc    = mtvec;
            flush_if       = 1'b1;
            flush_id       = 1'b1;
            flush_ex       = 1'b1;
            state_d        = RUN;
        end else if (ex_trap) begin
            // Capture the fault now, commit it next cycle; trap beats any redirect.
            cause_d  = ex_trap_cause;
            epc_d    = ex_pc;
            flush_if = 1'b1;
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = TRAP_ENTER;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
            csr_cnt_d = 2'd0;
`endif
        end else if (ex_jump_taken || ex_branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_jump_taken ? ex_jump_target : ex_branch_target;
            flush_if       = 1'b1;
            flush_id       = 1'b1;
            flush_ex       = 1'b1;
            // Redirect squashes anything younger, so a CSR drain in progress is moot.
            state_d        = RUN;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
            csr_cnt_d      = 2'd0;
        end else if (state == CSR_WAIT) begin
            stall_if  = 1'b1;
            flush_id  = 1'b1;
            csr_cnt_d = csr_cnt - 2'd1;
            if (csr_cnt <= 2'd1) begin
                state_d = RUN;
            end
`endif
        end else if (lu) begin
            // Single bubble; the load then moves on and the hazard clears itself.
            stall_if = 1'b1;
            flush_id = 1'b1;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
        end else if (id_is_csr) begin
            // CSR op advances this cycle; bubbles follow behind it.
            state_d   = CSR_WAIT;
            csr_cnt_d = 2'(CSR_DRAIN);
`endif
        end

        // Nothing leaves the block while held in reset.
        if (!resetn) begin
            stall_if       = 1'b0;
            stall_id       = 1'b0;
            stall_ex       = 1'b0;
            flush_if       = 1'b0;
            flush_id       = 1'b0;
            flush_ex       = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            trap_take      = 1'b0;
            trap_cause_out = 4'd0;
            trap_epc       = '0;
            busy           = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, redirect priority, trap sequencing, mem_busy, CSR drain, reset abort.
// Inputs change 1 ns after posedge; outputs are sampled at negedge.
// Control outputs are compared as {stall_if,stall_id,stall_ex,flush_if,flush_id,flush_ex,redirect_valid,trap_take,busy}.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_is_csr, ex_mem_read;
    logic        ex_branch_taken, ex_jump_taken, ex_trap, mem_busy;
    logic [63:0] ex_branch_target, ex_jump_target, ex_pc, mtvec;
    logic [3:0]  ex_trap_cause;
    logic        stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex;
    logic        redirect_valid, trap_take, busy;
    logic [63:0] redirect_pc, trap_epc;
    logic [3:0]  trap_cause_out;
    logic [8:0]  obs;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [8:0] NONE  = 9'b000_000_000;
    localparam logic [8:0] LUB   = 9'b100_010_000;
    localparam logic [8:0] REDIR = 9'b000_111_100;
    localparam logic [8:0] TDET  = 9'b000_111_000;
    localparam logic [8:0] TTAKE = 9'b000_111_111;
    localparam logic [8:0] MEMR  = 9'b111_000_000;
    localparam logic [8:0] MEMT  = 9'b111_000_001;
    localparam logic [8:0] CSRB  = 9'b100_010_001;

    always #5 clk = ~clk;

    assign obs = {stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex,
                  redirect_valid, trap_take, busy};

    pipe_ctrl #(.XLEN(64), .CSR_DRAIN(2)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_csr(id_is_csr), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_jump_taken(ex_jump_taken),
        .ex_branch_target(ex_branch_target), .ex_jump_target(ex_jump_target),
        .ex_trap(ex_trap), .ex_trap_cause(ex_trap_cause), .ex_pc(ex_pc), .mtvec(mtvec),
        .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_take(trap_take), .trap_cause_out(trap_cause_out), .trap_epc(trap_epc),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_is_csr = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_jump_taken = 1'b0;
        ex_branch_target = 64'h0; ex_jump_target = 64'h0;
        ex_trap = 1'b0; ex_trap_cause = 4'd0; ex_pc = 64'h0;
        mem_busy = 1'b0;
    endtask

    // Sample one cycle mid-period, then advance to just after the next posedge.
    task automatic cyc(input string tag, input logic [8:0] e, input logic [63:0] e_pc,
                       input logic [3:0] e_cause, input logic [63:0] e_epc);
        @(negedge clk);
        check({tag, ".ctl"},   64'(obs), 64'(e));
        check({tag, ".rpc"},   redirect_pc, e_pc);
        check({tag, ".cause"}, 64'(trap_cause_out), 64'(e_cause));
        check({tag, ".epc"},   trap_epc, e_epc);
        @(posedge clk); #1;
    endtask

    // Pulse reset mid-cycle with mem_busy high; every output must read 0.
    task automatic reset_pulse(input string tag);
        resetn = 1'b0;
        mem_busy = 1'b1;
        ex_trap = 1'b1;
        @(negedge clk);
        check({tag, ".ctl"}, 64'(obs), 64'(NONE));
        check({tag, ".rpc"}, redirect_pc, 64'h0);
        #1;
        resetn = 1'b1;
        idle();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        mtvec  = 64'h200;
        resetn = 1'b0;
        #1;
        reset_pulse("reset");
        cyc("idle", NONE, 64'h0, 4'd0, 64'h0);

        // Load-use via rs1, then bubble retires the load.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        cyc("lu_rs1", LUB, 64'h0, 4'd0, 64'h0);
        idle();
        cyc("lu_clear", NONE, 64'h0, 4'd0, 64'h0);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        cyc("lu_rs2", LUB, 64'h0, 4'd0, 64'h0);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        cyc("lu_unused", NONE, 64'h0, 4'd0, 64'h0);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        cyc("lu_x0", NONE, 64'h0, 4'd0, 64'h0);
        idle();

        // mem_busy beats a load-use hazard and a branch.
        mem_busy = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        ex_branch_taken = 1'b1; ex_branch_target = 64'h40;
        cyc("membusy_run", MEMR, 64'h0, 4'd0, 64'h0);
        idle();

        // Jump has priority over branch; branch alone uses its own target.
        ex_jump_taken = 1'b1; ex_jump_target = 64'h80;
        ex_branch_taken = 1'b1; ex_branch_target = 64'h40;
        cyc("jump_over_br", REDIR, 64'h80, 4'd0, 64'h0);
        ex_jump_taken = 1'b0;
        cyc("branch_only", REDIR, 64'h40, 4'd0, 64'h0);
        idle();

        // Trap with a simultaneous branch: trap wins, no redirect this cycle.
        ex_trap = 1'b1; ex_trap_cause = 4'd2; ex_pc = 64'h100;
        ex_branch_taken = 1'b1; ex_branch_target = 64'h40;
        cyc("trap_det", TDET, 64'h0, 4'd0, 64'h0);
        idle();
        cyc("trap_take", TTAKE, 64'h200, 4'd2, 64'h100);
        cyc("trap_after", NONE, 64'h0, 4'd0, 64'h0);

        // Trap commit held off by three mem_busy cycles.
        ex_trap = 1'b1; ex_trap_cause = 4'd5; ex_pc = 64'h300;
        cyc("trapmb_det", TDET, 64'h0, 4'd0, 64'h0);
        idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("trapmb_hold%0d", i), MEMT, 64'h0, 4'd0, 64'h0);
        mem_busy = 1'b0;
        cyc("trapmb_take", TTAKE, 64'h200, 4'd5, 64'h300);
        cyc("trapmb_after", NONE, 64'h0, 4'd0, 64'h0);

        // CSR op leaves ID, then the drain bubbles (built only with serialisation).
        id_is_csr = 1'b1;
        cyc("csr_issue", NONE, 64'h0, 4'd0, 64'h0);
        id_is_csr = 1'b0;
`ifdef PIPE_CTRL_CSR_SERIAL_EN
        cyc("csr_bub1", CSRB, 64'h0, 4'd0, 64'h0);
        cyc("csr_bub2", CSRB, 64'h0, 4'd0, 64'h0);
`else
        cyc("csr_off1", NONE, 64'h0, 4'd0, 64'h0);
        cyc("csr_off2", NONE, 64'h0, 4'd0, 64'h0);
`endif
        cyc("csr_done", NONE, 64'h0, 4'd0, 64'h0);

        // Reset in the middle of a CSR drain.
        id_is_csr = 1'b1;
        cyc("csr2_issue", NONE, 64'h0, 4'd0, 64'h0);
        id_is_csr = 1'b0;
        reset_pulse("rst_csr");
        cyc("rst_csr_after", NONE, 64'h0, 4'd0, 64'h0);

        // Reset while a trap is pending commit: no trap_take afterwards.
        ex_trap = 1'b1; ex_trap_cause = 4'd3; ex_pc = 64'h500;
        cyc("rst_trap_det", TDET, 64'h0, 4'd0, 64'h0);
        idle();
        reset_pulse("rst_trap");
        cyc("rst_trap_after", NONE, 64'h0, 4'd0, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
